// File: rtl/pending_req_sched_pkg.sv
// pending_req_sched_pkg: shared controller state enum and default request width.
package pending_req_sched_pkg;
    localparam int DEFAULT_WIDTH = 32;
    typedef enum logic {IDLE, HOLD} state_t;
endpackage

// File: rtl/pending_req_scheduler_priority_encoder.sv
// priority_encoder: combinational lowest-set-bit selector (one-hot and binary index).
module priority_encoder #(
    parameter int WIDTH   = 32,
    parameter int WIDTH_W = $clog2(WIDTH)
) (
    input  logic [WIDTH-1:0]   id,
    output logic               od_valid,
    output logic [WIDTH-1:0]   od_filt,
    output logic [WIDTH_W-1:0] od_bin
);
    assign od_valid = |id;
    // Two's complement isolates the lowest set bit.
    assign od_filt = id & (~id + 1'b1);
    always_comb begin
        od_bin = '0;
        for (int i = WIDTH - 1; i >= 0; i--)
            if (id[i]) od_bin = WIDTH_W'(i);
    end
endmodule

// File: rtl/pending_req_scheduler.sv
// pending_req_scheduler: sticky request register with fixed-priority grant output stage.
// Optional accepted-grant counter od_cnt is enabled by macro PENDING_REQ_SCHED_CNT_EN.
module pending_req_scheduler
    import pending_req_sched_pkg::*;
#(
    parameter int WIDTH   = DEFAULT_WIDTH,
    parameter int WIDTH_W = $clog2(WIDTH)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               id_valid,
    input  logic [WIDTH-1:0]   id,
    output logic               od_valid,
    input  logic               od_ready,
    output logic [WIDTH-1:0]   od_onehot,
    output logic [WIDTH_W-1:0] od_bin,
    output logic [WIDTH-1:0]   pend,
`ifdef PENDING_REQ_SCHED_CNT_EN
    output logic [15:0]        od_cnt,
`endif
    output logic               busy
);
    state_t               state;
    logic                 win_valid;
    logic [WIDTH-1:0]     win_filt;
    logic [WIDTH_W-1:0]   win_bin;
    logic                 free;
    logic                 load;

    priority_encoder #(.WIDTH(WIDTH), .WIDTH_W(WIDTH_W)) u_pe (
        .id       (pend),
        .od_valid (win_valid),
        .od_filt  (win_filt),
        .od_bin   (win_bin)
    );

    assign od_valid = state == HOLD;
    assign free     = !od_valid || od_ready;
    assign load     = free && win_valid;
    assign busy     = (|pend) | od_valid;

    // New requests are ORed after the winner is cleared so a same-edge re-request survives.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            pend      <= '0;
            od_onehot <= '0;
            od_bin    <= '0;
        end else begin
            pend <= (load ? pend & ~win_filt : pend) | (id_valid ? id : '0);
            if (free) state <= win_valid ? HOLD : IDLE;
            if (load) begin
                od_onehot <= win_filt;
                od_bin    <= win_bin;
            end
        end
    end

`ifdef PENDING_REQ_SCHED_CNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) od_cnt <= '0;
        else if (od_valid && od_ready) od_cnt <= od_cnt + 1'b1;
    end
`endif
endmodule

// File: tb/tb_pending_req_scheduler.sv
// tb_pending_req_scheduler: scoreboard bench with a set-based reference model and random traffic.
module tb_pending_req_scheduler;
    logic        clk = 0;
    logic        rst = 1;
    logic        id_valid = 0;
    logic [31:0] id = '0;
    logic        od_ready = 0;
    logic        od_valid;
    logic [31:0] od_onehot;
    logic [4:0]  od_bin;
    logic [31:0] pend;
    logic        busy;
`ifdef PENDING_REQ_SCHED_CNT_EN
    logic [15:0] od_cnt;
`endif

    pending_req_scheduler dut (
        .clk       (clk),
        .rst       (rst),
        .id_valid  (id_valid),
        .id        (id),
        .od_valid  (od_valid),
        .od_ready  (od_ready),
        .od_onehot (od_onehot),
        .od_bin    (od_bin),
        .pend      (pend),
`ifdef PENDING_REQ_SCHED_CNT_EN
        .od_cnt    (od_cnt),
`endif
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // Reference model: pending set, presented flag, queue of expected grant indices.
    logic [31:0] m_p = '0;
    logic        m_valid = 0;
    int          exp_q[$];
    int          m_cnt = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int lowest(input logic [31:0] v);
        for (int i = 0; i < 32; i++)
            if (v[i]) return i;
        return -1;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_p     = '0;
            m_valid = 0;
        end else begin
            if (!m_valid || od_ready) begin
                if (m_p != 0) begin
                    exp_q.push_back(lowest(m_p));
                    m_p[lowest(m_p)] = 1'b0;
                    m_valid = 1;
                end else m_valid = 0;
            end
            if (id_valid) m_p = m_p | id;
        end
    end

    logic        stall_prev = 0;
    logic [4:0]  prev_bin;
    logic [31:0] prev_oh;

    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
            m_cnt      = 0;
            stall_prev = 0;
        end else begin
            chk("od_valid", {63'b0, od_valid}, {63'b0, m_valid});
            chk("pend", {32'b0, pend}, {32'b0, m_p});
            chk("busy", {63'b0, busy}, {63'b0, (m_p != 0) || m_valid});
`ifdef PENDING_REQ_SCHED_CNT_EN
            chk("od_cnt", {48'b0, od_cnt}, 64'(m_cnt & 16'hFFFF));
`endif
            if (stall_prev) begin
                chk("hold_bin", {59'b0, od_bin}, {59'b0, prev_bin});
                chk("hold_onehot", {32'b0, od_onehot}, {32'b0, prev_oh});
            end
            if (od_valid && od_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL grant_unexpected: got bin %0d expected none at %0t", od_bin, $time);
                end else begin
                    int e;
                    e = exp_q.pop_front();
                    chk("grant_bin", {59'b0, od_bin}, 64'(e));
                    chk("grant_onehot", {32'b0, od_onehot}, 64'(1) << e);
                end
                m_cnt++;
            end
            stall_prev = od_valid && !od_ready;
            prev_bin   = od_bin;
            prev_oh    = od_onehot;
        end
    end

    task automatic drive(input logic v, input logic [31:0] d, input logic r);
        id_valid = v;
        id       = d;
        od_ready = r;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n, input logic r);
        for (int i = 0; i < n; i++) drive(0, '0, r);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", {63'b0, od_valid}, 64'd0);
        chk("rst_pend", {32'b0, pend}, 64'd0);
        chk("rst_onehot", {32'b0, od_onehot}, 64'd0);
        chk("rst_bin", {59'b0, od_bin}, 64'd0);
        rst = 0;
        idle(2, 1);
        // Two bits in one request, free stage.
        drive(1, 32'h0000_000C, 1);
        idle(4, 1);
        // Stall with two pending, then release.
        drive(1, 32'h0000_0005, 0);
        idle(5, 0);
        idle(4, 1);
        // Same-edge clear and re-set of bit 3.
        drive(1, 32'h0000_0008, 1);
        drive(1, 32'h0000_0008, 1);
        idle(4, 1);
        // Re-requesting an already pending line while stalled.
        drive(1, 32'h0000_0030, 0);
        drive(1, 32'h0000_0030, 0);
        drive(1, 32'h0000_0020, 0);
        idle(4, 1);
        // Full-width burst.
        drive(1, 32'hFFFF_FFFF, 1);
        idle(36, 1);
        // Request ignored without id_valid.
        drive(0, 32'h0000_0001, 1);
        idle(3, 1);
        // Mid-operation asynchronous reset with a grant presented and 0xF0 pending.
        drive(1, 32'h0000_00F1, 0);
        drive(0, '0, 0);
        #2;
        chk("pre_rst_pend", {32'b0, pend}, 64'h0F0);
        chk("pre_rst_valid", {63'b0, od_valid}, 64'd1);
        rst = 1;
        #1;
        chk("async_rst_valid", {63'b0, od_valid}, 64'd0);
        chk("async_rst_pend", {32'b0, pend}, 64'd0);
        @(posedge clk);
        #1;
        rst = 0;
        idle(4, 1);
        // Random traffic.
        for (int n = 0; n < 3000; n++)
            drive(1'($urandom_range(0, 2) == 0), $urandom & $urandom & $urandom, 1'($urandom_range(0, 3) != 0));
        // Drain with bounded wait.
        begin
            int k;
            k = 0;
            while ((m_p != 0 || m_valid) && k < 200) begin
                drive(0, '0, 1);
                k++;
            end
            if (k >= 200) begin
                checks++;
                failures++;
                $display("FAIL drain_timeout: got busy after %0d cycles expected idle", k);
            end
        end
        idle(2, 1);
        chk("queue_empty", 64'(exp_q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
